// File: rtl/decode_stage_if.sv
// Decode stage bus: fetch-side request, flush, and the registered decoded
// instruction presented to execute.
//
// Handshake: a transfer happens on a rising clk edge when in_valid && in_ready.
// in_ready = !out_valid || out_ready. The decoded result is held stable while
// out_valid && !out_ready, and consumed by execute when out_valid && out_ready.
interface decode_stage_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] pc;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm;
  logic [4:0]      alu_op;
  logic            use_imm;
  logic            use_pc;
  logic            word_op;
  logic            reg_write_enable;
  logic            mem_read;
  logic            mem_write;
  logic            is_branch;
  logic            jump;
  logic            jalr;
  logic            illegal;

  // Fetch/execute side of the stage
  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, pc, rd, rs1, rs2, funct3, imm, alu_op,
           use_imm, use_pc, word_op, reg_write_enable, mem_read, mem_write,
           is_branch, jump, jalr, illegal
  );

  // The decode stage itself
  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, pc, rd, rs1, rs2, funct3, imm, alu_op,
           use_imm, use_pc, word_op, reg_write_enable, mem_read, mem_write,
           is_branch, jump, jalr, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I (+ optional M) instruction decode stage. Decodes the incoming
// word combinationally and registers one decoded instruction per transfer.
module decode_stage #(
  parameter int XLEN = 64,
  parameter bit EN_M = 1'b0
) (
  input logic           clk,
  input logic           resetn,
  decode_stage_if.slave bus
);

  typedef enum logic [4:0] {
    ALU_NOP = 5'd0,  ALU_ADD = 5'd1,  ALU_SUB = 5'd2,  ALU_AND = 5'd3,
    ALU_OR  = 5'd4,  ALU_XOR = 5'd5,  ALU_SLL = 5'd6,  ALU_SRL = 5'd7,
    ALU_SRA = 5'd8,  ALU_SLT = 5'd9,  ALU_SLTU = 5'd10, ALU_MUL = 5'd11
  } alu_op_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam bit IS_RV32 = (XLEN == 32);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [4:0]      alu_op;
    logic            use_imm;
    logic            use_pc;
    logic            word_op;
    logic            reg_write_enable;
    logic            mem_read;
    logic            mem_write;
    logic            is_branch;
    logic            jump;
    logic            jalr;
    logic            illegal;
  } dec_t;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [4:0]      m_op;
  logic            bad;
  logic            out_valid_q;
  logic            xfer;
  dec_t            d;
  dec_t            q;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // All immediates sign-extend from instr[31]
  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));

  // MUL..REMU codes follow funct3 order starting at MUL
  assign m_op = ALU_MUL + {2'b00, f3};

  // Base integer op for funct7=0 / OP-IMM, indexed by funct3
  function automatic logic [4:0] base_op(input logic [2:0] f);
    case (f)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  // Combinational decode of the word currently presented by fetch
  always_comb begin
    d        = '0;
    bad      = 1'b0;
    d.pc     = bus.in_pc;
    d.rd     = instr[11:7];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.funct3 = f3;
    case (opcode)
      OPC_OP: begin
        d.reg_write_enable = 1'b1;
        if (f7 == 7'b0000001) begin
          if (EN_M) d.alu_op = m_op;
          else      bad = 1'b1;
        end else if (f7 == 7'b0000000) begin
          d.alu_op = base_op(f3);
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          d.alu_op = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          d.alu_op = ALU_SRA;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        d.use_imm          = 1'b1;
        d.reg_write_enable = 1'b1;
        d.imm              = imm_i;
        d.alu_op           = base_op(f3);
        if (f3 == 3'b101 && instr[30]) d.alu_op = ALU_SRA;
        // RV32 shift amounts are only 5 bits wide
        if ((f3 == 3'b001 || f3 == 3'b101) && IS_RV32 && instr[25]) bad = 1'b1;
      end
      OPC_OP32: begin
        d.word_op          = 1'b1;
        d.reg_write_enable = 1'b1;
        if (IS_RV32) bad = 1'b1;
        if (f7 == 7'b0000000 && f3 == 3'b000)      d.alu_op = ALU_ADD;
        else if (f7 == 7'b0000000 && f3 == 3'b001) d.alu_op = ALU_SLL;
        else if (f7 == 7'b0000000 && f3 == 3'b101) d.alu_op = ALU_SRL;
        else if (f7 == 7'b0100000 && f3 == 3'b000) d.alu_op = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101) d.alu_op = ALU_SRA;
        else if (f7 == 7'b0000001 && EN_M && (f3 == 3'b000 || f3[2])) d.alu_op = m_op;
        else bad = 1'b1;
      end
      OPC_OP_IMM32: begin
        d.word_op          = 1'b1;
        d.use_imm          = 1'b1;
        d.reg_write_enable = 1'b1;
        d.imm              = imm_i;
        if (IS_RV32) bad = 1'b1;
        case (f3)
          3'b000:  d.alu_op = ALU_ADD;
          3'b001:  d.alu_op = ALU_SLL;
          3'b101:  d.alu_op = instr[30] ? ALU_SRA : ALU_SRL;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.alu_op           = ALU_ADD;
        d.use_imm          = 1'b1;
        d.mem_read         = 1'b1;
        d.reg_write_enable = 1'b1;
        d.imm              = imm_i;
        if (f3 == 3'b111 || (IS_RV32 && (f3 == 3'b011 || f3 == 3'b110))) bad = 1'b1;
      end
      OPC_STORE: begin
        d.alu_op    = ALU_ADD;
        d.use_imm   = 1'b1;
        d.mem_write = 1'b1;
        d.imm       = imm_s;
        if (f3[2] || (IS_RV32 && f3 == 3'b011)) bad = 1'b1;
      end
      OPC_BRANCH: begin
        d.alu_op    = ALU_SUB;
        d.is_branch = 1'b1;
        d.imm       = imm_b;
        if (f3 == 3'b010 || f3 == 3'b011) bad = 1'b1;
      end
      OPC_LUI: begin
        d.alu_op           = ALU_ADD;
        d.use_imm          = 1'b1;
        d.reg_write_enable = 1'b1;
        d.imm              = imm_u;
        d.rs1              = 5'd0;
      end
      OPC_AUIPC: begin
        d.alu_op           = ALU_ADD;
        d.use_imm          = 1'b1;
        d.use_pc           = 1'b1;
        d.reg_write_enable = 1'b1;
        d.imm              = imm_u;
      end
      OPC_JAL: begin
        d.alu_op           = ALU_ADD;
        d.jump             = 1'b1;
        d.use_pc           = 1'b1;
        d.reg_write_enable = 1'b1;
        d.imm              = imm_j;
      end
      OPC_JALR: begin
        d.alu_op           = ALU_ADD;
        d.jump             = 1'b1;
        d.jalr             = 1'b1;
        d.use_imm          = 1'b1;
        d.reg_write_enable = 1'b1;
        d.imm              = imm_i;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        d.imm = imm_i;
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
    // Illegal words keep pc/fields but must not do anything downstream
    if (bad) begin
      d.alu_op           = ALU_NOP;
      d.use_imm          = 1'b0;
      d.use_pc           = 1'b0;
      d.word_op          = 1'b0;
      d.reg_write_enable = 1'b0;
      d.mem_read         = 1'b0;
      d.mem_write        = 1'b0;
      d.is_branch        = 1'b0;
      d.jump             = 1'b0;
      d.jalr             = 1'b0;
    end
    d.illegal = bad;
    if (d.rd == 5'd0) d.reg_write_enable = 1'b0;
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign xfer         = bus.in_valid && bus.in_ready;

  // Output register: flush beats a transfer, a stall holds everything
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q           <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q        <= 1'b0;
      q.reg_write_enable <= 1'b0;
      q.mem_read         <= 1'b0;
      q.mem_write        <= 1'b0;
      q.is_branch        <= 1'b0;
      q.jump             <= 1'b0;
      q.jalr             <= 1'b0;
      q.illegal          <= 1'b0;
    end else if (xfer) begin
      q           <= d;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid        = out_valid_q;
  assign bus.pc               = q.pc;
  assign bus.rd               = q.rd;
  assign bus.rs1              = q.rs1;
  assign bus.rs2              = q.rs2;
  assign bus.funct3           = q.funct3;
  assign bus.imm              = q.imm;
  assign bus.alu_op           = q.alu_op;
  assign bus.use_imm          = q.use_imm;
  assign bus.use_pc           = q.use_pc;
  assign bus.word_op          = q.word_op;
  assign bus.reg_write_enable = q.reg_write_enable;
  assign bus.mem_read         = q.mem_read;
  assign bus.mem_write        = q.mem_write;
  assign bus.is_branch        = q.is_branch;
  assign bus.jump             = q.jump;
  assign bus.jalr             = q.jalr;
  assign bus.illegal          = q.illegal;

endmodule
